mips_commit_tracer: RTL and testbench
=====================================

# mips_commit_tracer

Commit-side trace sink for the pipelined MIPS core. It captures register-file writebacks from the WB stage and data-memory stores from the MEM stage, and buffers them in a small FIFO. It serialises each event as a fixed 4-word record on a valid/ready stream, which the testbench or a debug port drains. Where the testbench drives stimulus into the core, this block carries the core's architectural results back out.

## Interface
- `DEPTH`, default 8: FIFO entries; power of two, minimum 2.
- `SEQ_W`, default 23: sequence-number width; fixed by header layout, not to be overridden.
- `clk` input, 1 bit: the single clock; all state is on the rising edge.
- `reset` input, 1 bit: asynchronous, active-low; 0 clears all state immediately.
- `wb_valid` input, 1 bit: a WB-stage register write commits this cycle.
- `wb_pc` input, 32 bits: PC of the committing instruction.
- `wb_reg` input, 5 bits: destination register.
- `wb_data` input, 32 bits: value written.
- `mw_valid` input, 1 bit: a MEM-stage store commits this cycle.
- `mw_pc` input, 32 bits: PC of the store.
- `mw_addr` input, 32 bits: byte address.
- `mw_data` input, 32 bits: store data.
- `out_valid` output, 1 bit: a record word is presented.
- `out_ready` input, 1 bit: the consumer accepts the word.
- `out_data` output, 32 bits: record word.
- `out_last` output, 1 bit: high on word 3 of a record.
- `overflow` output, 1 bit: sticky; at least one event has been dropped.
- `drop_cnt` output, 16 bits: dropped-event count, saturates at 16'hFFFF.

## Operation
- **Event filter:** a writeback with `wb_reg`==0 is ignored. It is not an event, not a drop, and does not consume a sequence number.
- **Sequence number:** `seq`, SEQ_W bits. It increments by 1 for every event, whether accepted or dropped, and wraps from 2^23-1 to 0. Gaps in the sequence therefore reveal drops.
- **Simultaneous events:** if both events are valid in the same cycle, the WB event takes seq n and is ordered first. The MEM event takes seq n+1.
- **Admission:** free space is DEPTH minus the registered count. A pop in the same cycle does not create space.
  - free ≥ 2: both events are pushed.
  - free = 1: the WB event is pushed and the MEM event is dropped.
  - free = 0: all events that cycle are dropped.
  - Each dropped event sets `overflow` and increments `drop_cnt` by one, saturating.
- **Entry contents:** type (0 = register, 1 = store), seq, reg (0 for stores), pc, addr (0 for register events), data.
- **Record format:**
  - word0 = {type, seq[22:0], 3'b000, reg}
  - word1 = pc
  - word2 = addr
  - word3 = data, with `out_last` high.
- **Serialiser states:** IDLE, W0, W1, W2, W3.
  - IDLE goes to W0 when the FIFO is non-empty.
  - Wk goes to Wk+1 on `out_valid` && `out_ready`.
  - On acceptance of W3, the head entry is popped. The state goes to W0 if another entry remains, otherwise to IDLE.
- **Handshake:** once `out_valid` rises, `out_data`/`out_last` hold stable until accepted. `out_valid` never drops without a transfer.

## Timing
- **Reset values:** `out_valid`=0, `out_last`=0, `out_data`=0, `overflow`=0, `drop_cnt`=0, seq=0, FIFO empty, state IDLE.
- **Reset mid-record:** the record is abandoned, and `out_valid` drops asynchronously.
- **Latency:** an event pushed in cycle t into an empty FIFO presents word0 in cycle t+1.
- **Throughput:** with `out_ready` held high, 4 cycles per record. Records are back-to-back with no bubble between word3 and the next word0.
- **Full-FIFO boundary:** a push attempted in the same cycle as the final pop that empties a full FIFO is still dropped, since free space uses the registered count.
- **Status timing:** `overflow` and `drop_cnt` update one cycle after the dropped event.
- **Wrap-around:** FIFO pointers are log2(DEPTH)+1 bits, and full/empty are distinguished by the MSB.

## Structure
- **Shared package `mips_trace_pkg`:**
  - type codes TRACE_REG=1'b0, TRACE_MEM=1'b1
  - SEQ_W
  - header bit positions
  - entry field widths (125-bit entry)
  - serialiser state encoding
- **Sub-module `trace_fifo`:** DEPTH×125 storage, two write ports (ordered: port A before port B), one read port, registered count. The top level holds the filter, seq/drop logic and serialiser.

## Test plan
- **Single writeback:** reset released, `wb_valid`=1, `wb_reg`=5, `wb_pc`=0x3000, `wb_data`=0x1234, `out_ready`=1.
  - Expect words 0x00000005, 0x00003000, 0x00000000, 0x00001234 in cycles t+1..t+4, with `out_last` on the 4th.
- **Simultaneous WB and store:** WB reg 8 plus store addr 0x10, data 0xFF, same cycle.
  - Expect the WB record with seq 0 first, then the store record with header 0x80000100 (seq 1).
- **Overflow:** hold `out_ready`=0 and issue 10 single WB events with DEPTH=8.
  - Expect 8 buffered, `overflow`=1, `drop_cnt`=2.
  - On drain, expect seqs 0..7. The next accepted event carries seq 10.
- **$0 filter and back-pressure:** a WB to reg 0 produces no record and no seq increment.
  - Toggle `out_ready` every cycle: each word is held stable until accepted, and no word is duplicated or lost.
- **Reset mid-record:** assert `reset`=0 during W2.
  - `out_valid` falls without waiting for a clock edge; after release, the next event has seq 0 and `drop_cnt`=0.

Source files
------------

// File: rtl/mips_commit_tracer_pkg.sv
// Shared definitions for the commit-side trace sink: record type codes,
// header layout, buffered entry format and serialiser state encoding.
package mips_trace_pkg;

  localparam logic TRACE_REG   = 1'b0;
  localparam logic TRACE_MEM   = 1'b1;
  localparam int   TRACE_SEQ_W = 23;

  localparam int HDR_TYPE_BIT = 31;
  localparam int HDR_SEQ_LSB  = 8;
  localparam int HDR_REG_LSB  = 0;

  localparam int REG_W   = 5;
  localparam int WORD_W  = 32;
  localparam int ENTRY_W = 1 + TRACE_SEQ_W + REG_W + 3 * WORD_W;  // 125 bits

  typedef struct packed {
    logic                   typ;
    logic [TRACE_SEQ_W-1:0] seq;
    logic [REG_W-1:0]       rd;
    logic [WORD_W-1:0]      pc;
    logic [WORD_W-1:0]      addr;
    logic [WORD_W-1:0]      data;
  } trace_entry_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_W0   = 3'd1,
    S_W1   = 3'd2,
    S_W2   = 3'd3,
    S_W3   = 3'd4
  } ser_state_e;

  function automatic logic [WORD_W-1:0] make_header(input trace_entry_t e);
    return {e.typ, e.seq, 3'b000, e.rd};
  endfunction

endpackage

// File: rtl/mips_commit_tracer_if.sv
// Commit-event inputs, record stream and drop status of the trace sink.
interface mips_commit_tracer_if;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        mw_valid;
  logic [31:0] mw_pc;
  logic [31:0] mw_addr;
  logic [31:0] mw_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        overflow;
  logic [15:0] drop_cnt;

  modport master (
    output wb_valid, wb_pc, wb_reg, wb_data,
    output mw_valid, mw_pc, mw_addr, mw_data,
    output out_ready,
    input  out_valid, out_data, out_last, overflow, drop_cnt
  );

  modport slave (
    input  wb_valid, wb_pc, wb_reg, wb_data,
    input  mw_valid, mw_pc, mw_addr, mw_data,
    input  out_ready,
    output out_valid, out_data, out_last, overflow, drop_cnt
  );
endinterface

// File: rtl/mips_commit_tracer_fifo.sv
// Trace entry FIFO: two ordered write ports (A lands before B), one read port,
// wrap-bit pointers and a registered occupancy count.
module trace_fifo
  import mips_trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_a_i,
  input  trace_entry_t                 entry_a_i,
  input  logic                         push_b_i,
  input  trace_entry_t                 entry_b_i,
  input  logic                         pop_i,
  output trace_entry_t                 head_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH):0]       count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  trace_entry_t  mem_q [DEPTH];
  logic [CW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
  logic [CW-1:0] wptr_b;

  assign wptr_b = wptr_q + CW'(1);

  // NOTE: storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_a_i) mem_q[wptr_q[AW-1:0]] <= entry_a_i;
    if (push_b_i) mem_q[wptr_b[AW-1:0]] <= entry_b_i;
  end

  always_comb begin
    wptr_d  = wptr_q + CW'(push_a_i) + CW'(push_b_i);
    rptr_d  = rptr_q + CW'(pop_i);
    count_d = count_q + CW'(push_a_i) + CW'(push_b_i) - CW'(pop_i);
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Equal pointers including the wrap bit means empty; differing wrap bit means full.
  assign empty_o = (wptr_q == rptr_q);
  assign head_o  = mem_q[rptr_q[AW-1:0]];
  assign count_o = count_q;
endmodule

// File: rtl/mips_commit_tracer.sv
// Commit trace sink: filters WB/MEM commit events, numbers them, buffers them
// and serialises each one as a 4-word record on a valid/ready stream.
module mips_commit_tracer
  import mips_trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int SEQ_W = TRACE_SEQ_W
) (
  input  logic                 clk,
  input  logic                 reset,
  mips_commit_tracer_if.slave  bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             wb_ev, mw_ev;
  logic [1:0]       n_ev, n_acc, n_drop;
  logic [CW-1:0]    count, free;
  logic             empty, push_a, push_b, pop, fire;
  trace_entry_t     entry_a, entry_b, head;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [15:0]      drop_q, drop_d;
  logic [16:0]      drop_sum;
  logic             overflow_q, overflow_d;
  ser_state_e       state_q, state_d;

  assign wb_ev = bus.wb_valid && (bus.wb_reg != 5'd0);
  assign mw_ev = bus.mw_valid;
  assign free  = CW'(DEPTH) - count;

  // Admission looks only at the registered count, so a same-cycle pop never frees a slot.
  always_comb begin
    n_ev = {1'b0, wb_ev} + {1'b0, mw_ev};
    if (free >= CW'(2))      n_acc = n_ev;
    else if (free == CW'(1)) n_acc = (n_ev != 2'd0) ? 2'd1 : 2'd0;
    else                     n_acc = 2'd0;
    n_drop = n_ev - n_acc;
  end

  assign push_a = (n_acc != 2'd0);
  assign push_b = (n_acc == 2'd2);

  // Port A carries the first event of the cycle; port B only ever carries a store behind a WB.
  always_comb begin
    entry_a      = '0;
    entry_a.typ  = wb_ev ? TRACE_REG : TRACE_MEM;
    entry_a.seq  = seq_q;
    entry_a.rd   = wb_ev ? bus.wb_reg : 5'd0;
    entry_a.pc   = wb_ev ? bus.wb_pc : bus.mw_pc;
    entry_a.addr = wb_ev ? 32'd0 : bus.mw_addr;
    entry_a.data = wb_ev ? bus.wb_data : bus.mw_data;
    entry_b      = '0;
    entry_b.typ  = TRACE_MEM;
    entry_b.seq  = seq_q + SEQ_W'(1);
    entry_b.pc   = bus.mw_pc;
    entry_b.addr = bus.mw_addr;
    entry_b.data = bus.mw_data;
  end

  always_comb begin
    seq_d      = seq_q + SEQ_W'(n_ev);
    drop_sum   = {1'b0, drop_q} + {15'b0, n_drop};
    drop_d     = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    overflow_d = overflow_q || (n_drop != 2'd0);
  end

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_a_i  (push_a),
    .entry_a_i (entry_a),
    .push_b_i  (push_b),
    .entry_b_i (entry_b),
    .pop_i     (pop),
    .head_o    (head),
    .empty_o   (empty),
    .count_o   (count)
  );

  assign fire = bus.out_valid && bus.out_ready;

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: if (!empty || push_a) state_d = S_W0;
      S_W0:   if (fire) state_d = S_W1;
      S_W1:   if (fire) state_d = S_W2;
      S_W2:   if (fire) state_d = S_W3;
      S_W3: begin
        if (fire) begin
          pop     = 1'b1;
          state_d = ((count > CW'(1)) || push_a) ? S_W0 : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      seq_q      <= '0;
      drop_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      seq_q      <= seq_d;
      drop_q     <= drop_d;
      overflow_q <= overflow_d;
    end
  end

  // Outputs decode straight from the state register, so reset drops out_valid at once.
  always_comb begin
    bus.out_data = 32'd0;
    unique case (state_q)
      S_W0:    bus.out_data = make_header(head);
      S_W1:    bus.out_data = head.pc;
      S_W2:    bus.out_data = head.addr;
      S_W3:    bus.out_data = head.data;
      default: bus.out_data = 32'd0;
    endcase
  end

  assign bus.out_valid = (state_q != S_IDLE);
  assign bus.out_last  = (state_q == S_W3);
  assign bus.overflow  = overflow_q;
  assign bus.drop_cnt  = drop_q;
endmodule

// File: tb/tb_mips_commit_tracer.sv
// Directed bench for mips_commit_tracer: record format, ordering, overflow,
// full-FIFO boundary, $0 filter with back-pressure and asynchronous reset.
module tb_mips_commit_tracer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mips_commit_tracer_if bus ();

  mips_commit_tracer #(.DEPTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // {out_valid, out_last, out_data} observed as one word
  wire [33:0] obs = {bus.out_valid, bus.out_last, bus.out_data};
  wire [16:0] status = {bus.overflow, bus.drop_cnt};

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    bus.wb_valid  = 1'b0;
    bus.wb_pc     = '0;
    bus.wb_reg    = '0;
    bus.wb_data   = '0;
    bus.mw_valid  = 1'b0;
    bus.mw_pc     = '0;
    bus.mw_addr   = '0;
    bus.mw_data   = '0;
    bus.out_ready = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
  endtask

  task automatic drive_wb(input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] data);
    bus.wb_valid = 1'b1;
    bus.wb_reg   = rd;
    bus.wb_pc    = pc;
    bus.wb_data  = data;
  endtask

  // Expected {valid, last, word} for word k of a record
  function automatic logic [33:0] exp_word(input logic typ, input int seq, input int rd,
                                           input logic [31:0] pc, input logic [31:0] addr,
                                           input logic [31:0] data, input int k);
    logic [31:0] hdr;
    hdr = {typ, seq[22:0], 3'b000, rd[4:0]};
    case (k)
      0:       return {2'b10, hdr};
      1:       return {2'b10, pc};
      2:       return {2'b10, addr};
      default: return {2'b11, data};
    endcase
  endfunction

  task automatic test_reset;
    reset = 1'b0;
    clear_inputs();
    repeat (2) tick();
    checks++;
    if (obs !== 34'h0) begin
      errors++;
      $display("FAIL reset_out got %h exp %h", obs, 34'h0);
    end
    checks++;
    if (status !== 17'h0) begin
      errors++;
      $display("FAIL reset_status got %h exp %h", status, 17'h0);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (obs !== 34'h0) begin
      errors++;
      $display("FAIL reset_idle got %h exp %h", obs, 34'h0);
    end
  endtask

  task automatic test_single_wb;
    logic [33:0] exp [4];
    exp = '{{2'b10, 32'h0000_0005}, {2'b10, 32'h0000_3000},
            {2'b10, 32'h0000_0000}, {2'b11, 32'h0000_1234}};
    do_reset();
    bus.out_ready = 1'b1;
    drive_wb(5'd5, 32'h3000, 32'h1234);
    tick();
    bus.wb_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs !== exp[k]) begin
        errors++;
        $display("FAIL single_wb w%0d got %h exp %h", k, obs, exp[k]);
      end
      tick();
    end
    checks++;
    if (obs !== 34'h0) begin
      errors++;
      $display("FAIL single_wb_idle got %h exp %h", obs, 34'h0);
    end
  endtask

  task automatic test_simultaneous;
    logic [33:0] exp [8];
    exp = '{{2'b10, 32'h0000_0008}, {2'b10, 32'h0000_0100},
            {2'b10, 32'h0000_0000}, {2'b11, 32'h0000_00AA},
            {2'b10, 32'h8000_0100}, {2'b10, 32'h0000_0104},
            {2'b10, 32'h0000_0010}, {2'b11, 32'h0000_00FF}};
    do_reset();
    bus.out_ready = 1'b1;
    drive_wb(5'd8, 32'h100, 32'hAA);
    bus.mw_valid = 1'b1;
    bus.mw_pc    = 32'h104;
    bus.mw_addr  = 32'h10;
    bus.mw_data  = 32'hFF;
    tick();
    bus.wb_valid = 1'b0;
    bus.mw_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (obs !== exp[k]) begin
        errors++;
        $display("FAIL simultaneous w%0d got %h exp %h", k, obs, exp[k]);
      end
      tick();
    end
    checks++;
    if (obs !== 34'h0) begin
      errors++;
      $display("FAIL simultaneous_idle got %h exp %h", obs, 34'h0);
    end
  endtask

  task automatic test_overflow;
    logic [33:0] e;
    logic [16:0] es;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive_wb(5'(i + 1), 32'h400 + 32'(4 * i), 32'(i));
      tick();
      es = (i >= 8) ? {1'b1, 16'(i - 7)} : 17'h0;
      checks++;
      if (status !== es) begin
        errors++;
        $display("FAIL overflow_status ev%0d got %h exp %h", i, status, es);
      end
      checks++;
      if (obs !== {2'b10, 32'h0000_0001}) begin
        errors++;
        $display("FAIL overflow_hold ev%0d got %h exp %h", i, obs, {2'b10, 32'h0000_0001});
      end
    end
    bus.wb_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 4; k++) begin
        e = exp_word(1'b0, r, r + 1, 32'h400 + 32'(4 * r), 32'h0, 32'(r), k);
        checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL overflow_drain r%0d w%0d got %h exp %h", r, k, obs, e);
        end
        tick();
      end
    end
    checks++;
    if (obs !== 34'h0) begin
      errors++;
      $display("FAIL overflow_empty got %h exp %h", obs, 34'h0);
    end
    drive_wb(5'd3, 32'h500, 32'h77);
    tick();
    bus.wb_valid = 1'b0;
    checks++;
    if (obs !== {2'b10, 32'h0000_0A03}) begin
      errors++;
      $display("FAIL overflow_next_seq got %h exp %h", obs, {2'b10, 32'h0000_0A03});
    end
    checks++;
    if (status !== {1'b1, 16'd2}) begin
      errors++;
      $display("FAIL overflow_sticky got %h exp %h", status, {1'b1, 16'd2});
    end
  endtask

  task automatic test_full_boundary;
    logic [33:0] e;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive_wb(5'(i + 1), 32'h400 + 32'(4 * i), 32'(i));
      tick();
    end
    bus.wb_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if (obs !== {2'b11, 32'h0000_0000}) begin
      errors++;
      $display("FAIL boundary_w3 got %h exp %h", obs, {2'b11, 32'h0000_0000});
    end
    // push while the full FIFO pops its head: must still be dropped
    drive_wb(5'd9, 32'h600, 32'h9);
    tick();
    checks++;
    if (status !== {1'b1, 16'd1}) begin
      errors++;
      $display("FAIL boundary_drop got %h exp %h", status, {1'b1, 16'd1});
    end
    drive_wb(5'd10, 32'h700, 32'hA);
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 4; k++) begin
        if (r < 7) e = exp_word(1'b0, r + 1, r + 2, 32'h400 + 32'(4 * (r + 1)), 32'h0, 32'(r + 1), k);
        else       e = exp_word(1'b0, 9, 10, 32'h700, 32'h0, 32'hA, k);
        checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL boundary_drain r%0d w%0d got %h exp %h", r, k, obs, e);
        end
        tick();
        bus.wb_valid = 1'b0;
      end
    end
    checks++;
    if (obs !== 34'h0) begin
      errors++;
      $display("FAIL boundary_empty got %h exp %h", obs, 34'h0);
    end
  endtask

  task automatic test_filter_backpressure;
    logic [33:0] exp [8];
    int idx;
    logic acc;
    exp = '{{2'b10, 32'h0000_0007}, {2'b10, 32'h0000_0020},
            {2'b10, 32'h0000_0000}, {2'b11, 32'h0000_0005},
            {2'b10, 32'h8000_0100}, {2'b10, 32'h0000_0024},
            {2'b10, 32'h0000_0040}, {2'b11, 32'h0000_0099}};
    do_reset();
    drive_wb(5'd0, 32'h1C, 32'hDEAD);
    tick();
    checks++;
    if (obs !== 34'h0) begin
      errors++;
      $display("FAIL filter_r0 got %h exp %h", obs, 34'h0);
    end
    drive_wb(5'd7, 32'h20, 32'h5);
    tick();
    bus.wb_valid = 1'b0;
    bus.mw_valid = 1'b1;
    bus.mw_pc    = 32'h24;
    bus.mw_addr  = 32'h40;
    bus.mw_data  = 32'h99;
    tick();
    bus.mw_valid = 1'b0;
    idx = 0;
    for (int cyc = 0; cyc < 40 && idx < 8; cyc++) begin
      bus.out_ready = cyc[0];
      #1;
      checks++;
      if (obs !== exp[idx]) begin
        errors++;
        $display("FAIL backpressure c%0d got %h exp %h", cyc, obs, exp[idx]);
      end
      acc = bus.out_valid && bus.out_ready;
      tick();
      if (acc) idx++;
    end
    checks++;
    if (idx !== 8) begin
      errors++;
      $display("FAIL backpressure_count got %0d exp %0d", idx, 8);
    end
    checks++;
    if (obs !== 34'h0) begin
      errors++;
      $display("FAIL backpressure_idle got %h exp %h", obs, 34'h0);
    end
  endtask

  task automatic test_reset_mid;
    logic [33:0] e;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive_wb(5'd4, 32'h40 + 32'(4 * i), 32'(i));
      tick();
    end
    bus.wb_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) tick();
    checks++;
    if (obs !== {2'b10, 32'h0} || status !== {1'b1, 16'd1}) begin
      errors++;
      $display("FAIL reset_mid_pre got %h/%h exp %h/%h", obs, status, {2'b10, 32'h0}, {1'b1, 16'd1});
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (obs !== 34'h0) begin
      errors++;
      $display("FAIL reset_mid_async got %h exp %h", obs, 34'h0);
    end
    checks++;
    if (status !== 17'h0) begin
      errors++;
      $display("FAIL reset_mid_status got %h exp %h", status, 17'h0);
    end
    #2 reset = 1'b1;
    tick();
    drive_wb(5'd6, 32'h60, 32'h1);
    tick();
    bus.wb_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      e = exp_word(1'b0, 0, 6, 32'h60, 32'h0, 32'h1, k);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset_mid_next w%0d got %h exp %h", k, obs, e);
      end
      tick();
    end
    checks++;
    if (obs !== 34'h0) begin
      errors++;
      $display("FAIL reset_mid_empty got %h exp %h", obs, 34'h0);
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_wb();
    test_simultaneous();
    test_overflow();
    test_full_boundary();
    test_filter_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
